// File: rtl/dram_pkg.sv
// dram_pkg: shared types and defaults for the data-RAM responder.
//   dram_state_t   - responder FSM state encoding
//   DEF_ADDR_W     - default address bits taken from the core address
//   DEF_DATA_W     - default stored word width
//   MAX_READ_LAT   - largest supported read latency (latency counter is 3 bits)
package dram_pkg;

  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_DATA_W   = 8;
  localparam int MAX_READ_LAT = 7;

  typedef enum logic [2:0] {
    INIT      = 3'd0,
    IDLE      = 3'd1,
    READ_WAIT = 3'd2,
    WRITE     = 3'd3,
    DONE      = 3'd4
  } dram_state_t;

endpackage

// File: rtl/dram_array.sv
// dram_array: single-port synchronous RAM, DEPTH x DATA_W, registered read.
// Contents are never reset. A write cycle does not update rdata, so rdata
// holds the last word read until the next enabled read.
//   clk   in  clock
//   en    in  port enable
//   we    in  write enable (valid with en)
//   addr  in  word address
//   wdata in  write data
//   rdata out registered read data
module dram_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/dram_responder.sv
// dram_responder: memory-side responder for the core's data-RAM interface,
// with a host load/unload port for preloading operands and reading results.
//   clk, rst                      clock, async active-low reset
//   read_DRAM, dram_wrEn          core read / write strobes (taken when status=1)
//   ar_out, bus_out               core address / write data (low DATA_W bits stored)
//   end_process, start            enter DONE / leave DONE
//   dram_out, status              core read data / ready flag
//   host_req, host_we, host_addr, host_wdata   host access request
//   host_ack, host_rdata          host completion pulse / read data
//   err_oor                       sticky: core used an address >= DEPTH
// Optional: define DRAM_RESPONDER_STATS_EN to add rd_count / wr_count
// (saturating counts of accepted core reads / writes, cleared by start).
// READ_LAT must be in 1..MAX_READ_LAT.
module dram_responder
  import dram_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_DRAM,
  input  logic              dram_wrEn,
  input  logic [15:0]       ar_out,
  input  logic [15:0]       bus_out,
  input  logic              end_process,
  output logic [DATA_W-1:0] dram_out,
  output logic              status,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              start,
  output logic              err_oor
`ifdef DRAM_RESPONDER_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  dram_state_t state, state_nxt;

  logic              in_idle, core_oor;
  logic              core_wr_acc, core_rd_acc, core_acc, host_go;
  logic [2:0]        rd_cnt;
  logic              rd_last, rd_oor, end_pend, finish_done;
  logic [ADDR_W-1:0] rd_addr;
  logic              host_rd_pend;
  logic [DATA_W-1:0] host_rdata_q;

  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  // Upper write-data bits are not stored.
  logic unused_bus_hi;
  assign unused_bus_hi = ^bus_out[15:DATA_W];

  // Request decode. end_process in IDLE takes precedence over a request in
  // the same cycle; a write beats a simultaneous read.
  assign in_idle     = (state == IDLE);
  assign core_oor    = |(ar_out >> ADDR_W);
  assign core_wr_acc = in_idle && !end_process && dram_wrEn;
  assign core_rd_acc = in_idle && !end_process && read_DRAM && !dram_wrEn;
  assign core_acc    = core_wr_acc || core_rd_acc;
  // host_ack high blocks re-acceptance of a still-asserted host_req, which
  // limits the host to one access per two cycles.
  assign host_go     = host_req && !host_ack &&
                       ((in_idle && !core_acc) || state == DONE);
  assign rd_last     = (state == READ_WAIT) && (rd_cnt == 3'd0);
  assign finish_done = end_pend || end_process;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= INIT;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:      state_nxt = IDLE;
      IDLE: begin
        if (end_process)      state_nxt = DONE;
        else if (core_wr_acc) state_nxt = WRITE;
        else if (core_rd_acc) state_nxt = READ_WAIT;
      end
      READ_WAIT: if (rd_last) state_nxt = finish_done ? DONE : IDLE;
      WRITE:     state_nxt = finish_done ? DONE : IDLE;
      DONE:      if (start) state_nxt = IDLE;
      default:   state_nxt = INIT;
    endcase
  end

  // Outputs and RAM port mux. The core owns the port in IDLE when it has an
  // accepted request; during READ_WAIT the latched address is re-read so
  // rdata stays on the word being fetched; otherwise the host may use it.
  always_comb begin
    status    = in_idle;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = host_addr;
    ram_wdata = host_wdata;
    if (core_acc) begin
      ram_en    = 1'b1;
      ram_we    = core_wr_acc && !core_oor;
      ram_addr  = ar_out[ADDR_W-1:0];
      ram_wdata = bus_out[DATA_W-1:0];
    end else if (state == READ_WAIT) begin
      ram_en    = 1'b1;
      ram_addr  = rd_addr;
    end else if (host_go) begin
      ram_en    = 1'b1;
      ram_we    = host_we;
    end
  end

  dram_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Read latency tracking, core read data, host response, error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt       <= '0;
      rd_oor       <= 1'b0;
      rd_addr      <= '0;
      end_pend     <= 1'b0;
      dram_out     <= '0;
      host_ack     <= 1'b0;
      host_rd_pend <= 1'b0;
      host_rdata_q <= '0;
      err_oor      <= 1'b0;
    end else begin
      host_ack     <= host_go;
      host_rd_pend <= host_go && !host_we;
      if (host_rd_pend) host_rdata_q <= ram_rdata;

      if (core_rd_acc) begin
        rd_cnt  <= 3'(READ_LAT - 1);
        rd_oor  <= core_oor;
        rd_addr <= ar_out[ADDR_W-1:0];
      end else if (state == READ_WAIT && rd_cnt != 3'd0) begin
        rd_cnt <= rd_cnt - 3'd1;
      end

      // Out-of-range reads still take the full latency but return zero.
      if (rd_last) dram_out <= rd_oor ? '0 : ram_rdata;

      if (core_acc && core_oor) err_oor <= 1'b1;

      // Remember end_process raised mid-transaction until DONE is reached.
      if (state == DONE)
        end_pend <= 1'b0;
      else if ((state == READ_WAIT || state == WRITE) && end_process)
        end_pend <= 1'b1;
    end
  end

  // Read data is live from the RAM on the ack cycle, then held.
  assign host_rdata = host_rd_pend ? ram_rdata : host_rdata_q;

`ifdef DRAM_RESPONDER_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (state == DONE && start) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (core_rd_acc && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      if (core_wr_acc && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/dram_responder.md
Name: dram_responder

Overview:
- Memory-side responder for the single-core processor's data-RAM interface.
- Receives the core's address (ar_out), write data (bus_out), read_DRAM and dram_wrEn strobes.
- Returns dram_out, and a status ready flag the core waits on.
- Also holds a host load/unload port, used to preload matrix operands and read back results around an end_process run.

Parameters:
- ADDR_W, 8: address bits used from ar_out; DEPTH = 2**ADDR_W words.
- DATA_W, 8: stored word width; dram_out width.
- READ_LAT, 2: cycles from accepted read to data valid (1..7).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- read_DRAM  in  1  core read request, sampled when status=1.
- dram_wrEn  in  1  core write request, sampled when status=1.
- ar_out  in  16  core address.
- bus_out  in  16  core write data; bits [DATA_W-1:0] are stored.
- end_process  in  1  core finished; moves responder to DONE.
- dram_out  out  DATA_W  read data to core.
- status  out  1  1 = idle and ready to accept a core request.
- host_req  in  1  host access request.
- host_we  in  1  host write (1) / read (0).
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_ack  out  1  one-cycle pulse: host access done.
- host_rdata  out  DATA_W  host read data, valid with host_ack.
- start  in  1  pulse; leaves DONE and re-arms the core interface.
- err_oor  out  1  sticky: core accessed ar_out >= DEPTH.

Behaviour:
- States: INIT, IDLE, READ_WAIT, WRITE, DONE.
- Reset (rst=0, asynchronous):
  - state=INIT; dram_out=0, status=0, host_ack=0, host_rdata=0, err_oor=0.
  - Array contents are not cleared.
- INIT: one cycle after reset release, then IDLE; status=1 from that edge.
- IDLE, dram_wrEn=1:
  - Write bus_out[DATA_W-1:0] at ar_out[ADDR_W-1:0] on that edge.
  - Go to WRITE; status=0 for exactly one cycle, then back to IDLE.
- IDLE, read_DRAM=1 (and dram_wrEn=0):
  - Latch the address and go to READ_WAIT; status=0.
  - A latency counter counts READ_LAT cycles.
  - On the final edge, dram_out takes the stored word, status=1, state=IDLE.
  - dram_out holds its value until the next read completes.
- read_DRAM and dram_wrEn both high: the write wins; the read is dropped.
- Requests while status=0 are ignored; the core must hold its request until status=1.
- Out-of-range address (ar_out[15:ADDR_W] != 0):
  - Write is suppressed; read returns 0 with normal latency.
  - err_oor sets and stays set until reset.
- Host access:
  - Served only in IDLE or DONE, on a cycle with no accepted core request. A core request in the same IDLE cycle takes priority and the host waits.
  - Host write: commits on the accepting edge; host_ack the next cycle.
  - Host read: host_rdata and host_ack the next cycle.
  - host_req must stay high until host_ack.
  - Back-to-back host accesses are allowed at one per two cycles.
- end_process=1 in IDLE → DONE. In READ_WAIT or WRITE, the transaction completes first, then DONE.
- DONE:
  - status=0; core requests ignored; host access allowed.
  - start pulse → IDLE with status=1 the next cycle.
  - start in any other state is ignored.
- Reset mid-READ_WAIT aborts the read; dram_out=0.

Optional Feature:
- Macro: DRAM_RESPONDER_STATS_EN.
- Defined: adds outputs rd_count[15:0] and wr_count[15:0].
  - They count accepted core reads and writes, saturating at 16'hFFFF.
  - Cleared by reset and by start.
- Undefined: no counters and no extra ports.

Decomposition:
- Package dram_pkg holds:
  - State enum dram_state_t {INIT, IDLE, READ_WAIT, WRITE, DONE}.
  - Localparams DEF_ADDR_W=8, DEF_DATA_W=8, MAX_READ_LAT=7.
- Sub-module dram_array:
  - Single-port synchronous RAM, DEPTH x DATA_W, registered read.
  - No reset on contents; the responder muxes core and host onto its port.

Test Plan:
- Reset then idle: rst low 3 cycles, release → status=0 for one cycle, then 1; dram_out=0, err_oor=0.
- Host preload then core read: host writes 8'h23 at addr 5 (ack one cycle later); core read_DRAM with ar_out=5 → status low 2 cycles, then dram_out=8'h23 and status=1.
- Core write then host read:
  - dram_wrEn with ar_out=10 and bus_out=16'h01C4 → status low one cycle.
  - Host read of addr 10 → host_rdata=8'hC4.
- Simultaneous read_DRAM and dram_wrEn, ar_out=3, bus_out=16'h0007 → word 3 becomes 7; dram_out unchanged.
- Out-of-range: read ar_out=16'h0100 → dram_out=0 after READ_LAT, err_oor=1; a write to 16'h0100 leaves all words unchanged.
- End/restart:
  - end_process during READ_WAIT → read completes, then status=0 in DONE; read_DRAM is ignored.
  - Host read works; start pulse → status=1 next cycle (counters=0 if DRAM_RESPONDER_STATS_EN).
